// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fft_pkg                                                |
// | Description : Shared types and constants for the FFT stage           |
// |               scheduler: FSM state encoding, error-flag bit indices  |
// |               and a small width helper.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fft_pkg;

    // Scheduler FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } fft_state_e;

    // Sticky error flag layout
    localparam int c_err_w       = 3;
    localparam int c_err_timeout = 0;
    localparam int c_err_seq     = 1;
    localparam int c_err_overrun = 2;

    // Index width that never collapses to zero bits
    function automatic int clog2_min1(input int value);
        if (value <= 2) begin
            return 1;
        end
        return $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fft_watchdog                                           |
// | Description : Progress watchdog. Counts enabled cycles without a     |
// |               kick and flags expiry on the cycle the count would     |
// |               reach TIMEOUT.                                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fft_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    input  logic enable,
    output logic expired
);

    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_count;

    // Expiry is decided combinationally so the scheduler can react at the
    // same edge the count would hit TIMEOUT; a kick always wins.
    assign expired = enable && !kick && (r_count == c_last);

    // Idle-cycle counter: cleared by progress, by leaving the watched
    // states and after firing
    always_ff @(posedge clk) begin
        if (rst || kick || !enable || expired) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_stage_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fft_stage_scheduler                                    |
// | Description : Sequences one FFT frame through a chain of pipelined   |
// |               stages: loads N samples, fires one start pulse per     |
// |               stage as the previous one completes, drains N output   |
// |               samples, and guards the whole run with a watchdog.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fft_stage_scheduler
    import fft_pkg::*;
#(
    parameter int N          = 16,
    parameter int SIZE       = 4,
    parameter int NUM_STAGES = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic                  out_valid,
    output logic                  in_ready,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  abort,
    output logic [c_err_w-1:0]    err
);

    localparam int c_cnt_w = SIZE + 1;
    localparam int c_idx_w = clog2_min1(NUM_STAGES);
    localparam logic [c_cnt_w-1:0]    c_last_cnt = c_cnt_w'(N - 1);
    localparam logic [c_idx_w-1:0]    c_last_idx = c_idx_w'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] c_stage0   = NUM_STAGES'(1);

    // Architectural state
    fft_state_e            r_state;
    logic [c_cnt_w-1:0]    r_in_cnt;
    logic [c_cnt_w-1:0]    r_out_cnt;
    logic [c_idx_w-1:0]    r_idx;
    logic                  r_pending;

    // Registered outputs
    logic                  r_in_ready;
    logic [NUM_STAGES-1:0] r_stage_start;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_abort;
    logic [c_err_w-1:0]    r_err;

    // Next-state values from input events (before watchdog override)
    fft_state_e            w_state_evt;
    logic [c_cnt_w-1:0]    w_in_cnt_next;
    logic [c_cnt_w-1:0]    w_out_cnt_next;
    logic [c_idx_w-1:0]    w_idx_next;
    logic                  w_pending_evt;
    logic [NUM_STAGES-1:0] w_stage_start_next;
    logic                  w_frame_done_next;
    logic [c_err_w-1:0]    w_err_evt;

    // Final next-state values
    fft_state_e            w_state_next;
    logic                  w_pending_next;
    logic [c_err_w-1:0]    w_err_set;

    logic [NUM_STAGES-1:0] w_expect;
    logic                  w_done_hit;
    logic                  w_done_stray;
    logic                  w_kick;
    logic                  w_wd_enable;
    logic                  w_wd_expired;

    // Only the completion of the currently running stage advances the
    // chain; anything else on stage_done is a sequencing fault.
    assign w_expect     = c_stage0 << r_idx;
    assign w_done_hit   = (r_state == ST_RUN) && (|(stage_done & w_expect));
    assign w_done_stray = (r_state == ST_RUN) ? (|(stage_done & ~w_expect))
                                              : (|stage_done);

    // Event-driven next state, counters, pulses and error sources
    always_comb begin
        w_state_evt        = r_state;
        w_in_cnt_next      = r_in_cnt;
        w_out_cnt_next     = r_out_cnt;
        w_idx_next         = r_idx;
        w_pending_evt      = r_pending;
        w_stage_start_next = '0;
        w_frame_done_next  = 1'b0;
        w_err_evt          = '0;
        w_err_evt[c_err_seq] = w_done_stray;

        // A request while busy is remembered once; a second one is lost
        if (start && (r_state != ST_IDLE)) begin
            if (r_pending) begin
                w_err_evt[c_err_overrun] = 1'b1;
            end else begin
                w_pending_evt = 1'b1;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (start || r_pending) begin
                    w_state_evt   = ST_LOAD;
                    w_in_cnt_next = '0;
                    w_pending_evt = 1'b0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (r_in_cnt == c_last_cnt) begin
                        w_state_evt        = ST_RUN;
                        w_in_cnt_next      = '0;
                        w_idx_next         = '0;
                        w_stage_start_next = c_stage0;
                    end else begin
                        w_in_cnt_next = r_in_cnt + c_cnt_w'(1);
                    end
                end
            end
            ST_RUN: begin
                if (w_done_hit) begin
                    if (r_idx == c_last_idx) begin
                        w_state_evt    = ST_DRAIN;
                        w_out_cnt_next = '0;
                    end else begin
                        w_idx_next         = r_idx + c_idx_w'(1);
                        w_stage_start_next = w_expect << 1;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid) begin
                    if (r_out_cnt == c_last_cnt) begin
                        w_frame_done_next = 1'b1;
                        w_out_cnt_next    = '0;
                        // A request arriving with the last sample counts
                        // as pending, so the next frame follows directly
                        if (w_pending_evt) begin
                            w_state_evt   = ST_LOAD;
                            w_in_cnt_next = '0;
                            w_pending_evt = 1'b0;
                        end else begin
                            w_state_evt = ST_IDLE;
                        end
                    end else begin
                        w_out_cnt_next = r_out_cnt + c_cnt_w'(1);
                    end
                end
            end
            default: begin
                w_state_evt = ST_IDLE;
            end
        endcase
    end

    // Any sample or stage activity, or a state change, counts as progress
    assign w_kick      = in_valid | (|stage_done) | out_valid | (w_state_evt != r_state);
    assign w_wd_enable = (r_state == ST_RUN) || (r_state == ST_DRAIN);

    fft_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .kick    (w_kick),
        .enable  (w_wd_enable),
        .expired (w_wd_expired)
    );

    // Watchdog expiry overrides the event path and abandons the frame
    always_comb begin
        w_state_next   = w_state_evt;
        w_pending_next = w_pending_evt;
        w_err_set      = w_err_evt;
        if (w_wd_expired) begin
            w_state_next             = ST_IDLE;
            w_pending_next           = 1'b0;
            w_err_set[c_err_timeout] = 1'b1;
        end
    end

    // FSM state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_idx     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_in_cnt  <= w_in_cnt_next;
            r_out_cnt <= w_out_cnt_next;
            r_idx     <= w_idx_next;
            r_pending <= w_pending_next;
        end
    end

    // Output registers; status outputs track the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready    <= 1'b0;
            r_stage_start <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_abort       <= 1'b0;
            r_err         <= '0;
        end else begin
            r_in_ready    <= (w_state_next == ST_LOAD);
            r_stage_start <= w_stage_start_next;
            r_busy        <= (w_state_next != ST_IDLE);
            r_frame_done  <= w_frame_done_next;
            r_abort       <= w_wd_expired;
            r_err         <= r_err | w_err_set;
        end
    end

    assign in_ready    = r_in_ready;
    assign stage_start = r_stage_start;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign abort       = r_abort;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fft_stage_scheduler                                 |
// | Description : Self-checking bench for fft_stage_scheduler: a table   |
// |               of idle/reset vectors plus frame-level sequences whose |
// |               expected pulses are queued with their due cycle.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fft_stage_scheduler;

    localparam int N  = 16;
    localparam int NS = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [NS-1:0] stage_done;
    logic          out_valid;
    logic          in_ready;
    logic [NS-1:0] stage_start;
    logic          busy;
    logic          frame_done;
    logic          abort;
    logic [2:0]    err;

    fft_stage_scheduler #(
        .N          (N),
        .SIZE       (4),
        .NUM_STAGES (NS),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .stage_done  (stage_done),
        .out_valid   (out_valid),
        .in_ready    (in_ready),
        .stage_start (stage_start),
        .busy        (busy),
        .frame_done  (frame_done),
        .abort       (abort),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec    = 0;
    int n_miss   = 0;
    int n_frames = 0;

    // Expected pulse event and the cycle it is due
    typedef struct {
        logic [NS-1:0] ss;
        logic          fd;
        logic          ab;
        int            at;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        logic          r;
        logic          s;
        logic          iv;
        logic [NS-1:0] sd;
        logic          ov;
        logic          exp_rdy;
        logic          exp_busy;
        logic [2:0]    exp_err;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every observed pulse must match the head of the scoreboard
    task automatic monitor();
        ev_t e;
        if ((stage_start != '0) || frame_done || abort) begin
            if (frame_done) n_frames++;
            chk("stage_start_onehot", {31'd0, $countones(stage_start) <= 1}, 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {26'd0, stage_start, frame_done, abort}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_value", {26'd0, stage_start, frame_done, abort}, {26'd0, e.ss, e.fd, e.ab});
                chk("pulse_cycle", cyc, e.at);
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic iv,
                        input logic [NS-1:0] sd, input logic ov);
        @(negedge clk);
        monitor();
        rst        = r;
        start      = s;
        in_valid   = iv;
        stage_done = sd;
        out_valid  = ov;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic expect_ev(input logic [NS-1:0] e_ss, input logic e_fd,
                             input logic e_ab, input int dly);
        sb.push_back('{e_ss, e_fd, e_ab, cyc + dly});
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle();
    endtask

    task automatic load_frame();
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b0, 1'b1, '0, 1'b0);
            chk("in_ready_load", {31'd0, in_ready}, 32'd1);
        end
        expect_ev(4'b0001, 1'b0, 1'b0, 1);
    endtask

    task automatic run_stages(input int gap);
        for (int s = 0; s < NS; s++) begin
            repeat (gap - 1) idle();
            step(1'b0, 1'b0, 1'b0, NS'(1) << s, 1'b0);
            if (s < NS - 1) expect_ev(NS'(1) << (s + 1), 1'b0, 1'b0, 1);
        end
    endtask

    task automatic drain_frame(input logic start_last);
        for (int i = 0; i < N; i++) begin
            step(1'b0, (i == N - 1) ? start_last : 1'b0, 1'b0, '0, 1'b1);
        end
        expect_ev('0, 1'b1, 1'b0, 1);
    endtask

    initial begin
        int f0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; stage_done = '0; out_valid = 1'b0;

        //          r  s  iv  sd       ov  rdy busy err
        vt[0] = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000};
        vt[1] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000};
        vt[2] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000};
        vt[3] = '{1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 3'b010};
        vt[4] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 3'b010};
        vt[5] = '{1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 3'b010};
        vt[6] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 3'b010};
        vt[7] = '{1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 3'b010};
        vt[8] = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000};
        vt[9] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000};

        // Row i's response is visible at the negedge after it is driven
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) step(vt[i].r, vt[i].s, vt[i].iv, vt[i].sd, vt[i].ov);
            else        idle();
            if (i > 0) begin
                chk($sformatf("vec%0d_rdy_busy_err", i - 1),
                    {27'd0, in_ready, busy, err},
                    {27'd0, vt[i-1].exp_rdy, vt[i-1].exp_busy, vt[i-1].exp_err});
            end
        end

        // Nominal frame
        do_reset();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        load_frame();
        run_stages(10);
        drain_frame(1'b0);
        idle();
        idle();
        chk("nominal_err", {29'd0, err}, 32'd0);
        chk("nominal_idle", {30'd0, busy, in_ready}, 32'd0);
        chk("nominal_sb_empty", sb.size(), 0);

        // Back-to-back: start during RUN, then start with the last out_valid
        do_reset();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        load_frame();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        run_stages(10);
        drain_frame(1'b0);
        idle();
        chk("b2b_direct_load", {30'd0, busy, in_ready}, 32'd3);
        load_frame();
        run_stages(10);
        drain_frame(1'b1);
        idle();
        chk("same_cycle_start_load", {30'd0, busy, in_ready}, 32'd3);
        load_frame();
        run_stages(10);
        drain_frame(1'b0);
        idle();
        idle();
        chk("b2b_err", {29'd0, err}, 32'd0);
        chk("b2b_sb_empty", sb.size(), 0);

        // Overrun: three extra starts during LOAD
        do_reset();
        f0 = n_frames;
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < N; i++) begin
            step(1'b0, (i == 2 || i == 5 || i == 9), 1'b1, '0, 1'b0);
        end
        expect_ev(4'b0001, 1'b0, 1'b0, 1);
        run_stages(10);
        drain_frame(1'b0);
        load_frame();
        run_stages(10);
        drain_frame(1'b0);
        repeat (4) idle();
        chk("overrun_err", {29'd0, err}, 32'd4);
        chk("overrun_frames", n_frames - f0, 2);
        chk("overrun_idle", {31'd0, busy}, 32'd0);
        chk("overrun_sb_empty", sb.size(), 0);

        // Stall: stage_done[2] never arrives
        do_reset();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        load_frame();
        repeat (9) idle();
        step(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
        expect_ev(4'b0010, 1'b0, 1'b0, 1);
        repeat (9) idle();
        step(1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
        expect_ev(4'b0100, 1'b0, 1'b0, 1);
        expect_ev('0, 1'b0, 1'b1, 1 + TO);
        repeat (TO + 6) idle();
        chk("stall_err", {29'd0, err}, 32'd1);
        chk("stall_idle", {30'd0, busy, in_ready}, 32'd0);
        chk("stall_sb_empty", sb.size(), 0);

        // Sequence error: stage_done[3] while stage 1 is running
        do_reset();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        load_frame();
        repeat (9) idle();
        step(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
        expect_ev(4'b0010, 1'b0, 1'b0, 1);
        repeat (4) idle();
        step(1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
        repeat (4) idle();
        step(1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
        expect_ev(4'b0100, 1'b0, 1'b0, 1);
        repeat (9) idle();
        step(1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
        expect_ev(4'b1000, 1'b0, 1'b0, 1);
        repeat (9) idle();
        step(1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
        drain_frame(1'b0);
        idle();
        idle();
        chk("seq_err", {29'd0, err}, 32'd2);
        chk("seq_idle", {31'd0, busy}, 32'd0);
        chk("seq_sb_empty", sb.size(), 0);

        // Reset mid-load, then a clean frame
        do_reset();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b1, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle();
        chk("midreset_outputs", {22'd0, in_ready, stage_start, busy, frame_done, abort, err},
            32'd0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        load_frame();
        run_stages(10);
        drain_frame(1'b0);
        idle();
        idle();
        chk("midreset_err", {29'd0, err}, 32'd0);
        chk("midreset_idle", {31'd0, busy}, 32'd0);
        chk("midreset_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_stage_scheduler.md
FFT_STAGE_SCHEDULER -- requirements
Module: fft_stage_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning FFT points per frame (power of 2, at least 4).
REQ-002 The block SHALL have parameter SIZE, default 4, meaning log2(N) and the sample-counter width.
REQ-003 The block SHALL have parameter NUM_STAGES, default 4, meaning the number of pipelined FFT stages to be sequenced (equal to SIZE).
REQ-004 The block SHALL have parameter TIMEOUT, default 64, meaning the watchdog limit in cycles without progress.
REQ-005 clk  input  1  the single clock; all logic is on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 start  input  1  frame request pulse.
REQ-008 in_valid  input  1  input sample strobe into stage 0.
REQ-009 stage_done  input  NUM_STAGES  per-stage completion pulses (each stage's start_next_stage).
REQ-010 out_valid  input  1  output sample strobe from the last stage.
REQ-011 in_ready  output  1  high when input samples are accepted.
REQ-012 stage_start  output  NUM_STAGES  one-hot single-cycle start pulses, one bit per stage.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_done  output  1  single-cycle end-of-frame pulse.
REQ-015 abort  output  1  single-cycle pulse when the watchdog aborts a frame.
REQ-016 err  output  3  sticky flags: [0] timeout, [1] sequence error, [2] start overrun.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, RUN and DRAIN.
REQ-018 In IDLE, start (or a pending start) SHALL cause the next cycle to be LOAD with the sample counter at 0.
REQ-019 In LOAD, in_ready SHALL be 1 and each in_valid SHALL increment the sample counter; in_valid outside LOAD SHALL be ignored.
REQ-020 On the N-th in_valid, stage_start[0] SHALL pulse on the following cycle, the FSM SHALL go to RUN, and the stage index SHALL be 0.
REQ-021 In RUN, stage_done[idx] SHALL produce a stage_start[idx+1] pulse on the next cycle and increment idx, for idx < NUM_STAGES-1.
REQ-022 In RUN, stage_done[NUM_STAGES-1] SHALL move the FSM to DRAIN with the output counter at 0.
REQ-023 Any stage_done bit other than bit idx, asserted in RUN, SHALL set err[1] and otherwise be ignored.
REQ-024 Any stage_done bit asserted outside RUN SHALL set err[1] and otherwise be ignored.
REQ-025 In DRAIN, each out_valid SHALL increment the output counter.
REQ-026 On the N-th out_valid, frame_done SHALL pulse on the next cycle and the FSM SHALL enter IDLE.
REQ-027 When a start is pending at that point, the FSM SHALL go directly to LOAD instead of IDLE, and the pending flag SHALL clear.
REQ-028 A start while busy SHALL set a one-deep pending flag; a start while pending is already set SHALL set err[2] and be dropped.
REQ-029 The watchdog SHALL reset to 0 on every in_valid, stage_done or out_valid, and on every state change.
REQ-030 The watchdog SHALL count only in RUN and DRAIN.
REQ-031 When the watchdog reaches TIMEOUT, the block SHALL set err[0], pulse abort, clear pending and enter IDLE.
REQ-032 Counter wrap SHALL NOT occur, because terminal counts trigger state changes; counters SHALL be SIZE+1 bits.
REQ-033 When start and the final out_valid occur in the same cycle, the start SHALL be treated as pending.
REQ-034 stage_start SHALL never have more than one bit set in any cycle.
REQ-035 err SHALL clear only on reset.

Reset
REQ-036 While rst is high, the block SHALL set state IDLE, all counters 0, pending 0, stage_start 0, frame_done 0, abort 0, err 0, busy 0 and in_ready 0.
REQ-037 Reset mid-frame SHALL discard the frame without producing a frame_done or abort pulse.

Structure
REQ-038 The FSM state enum and the err bit indices SHALL be defined in the shared package fft_pkg.
REQ-039 The watchdog SHALL be a single sub-module, fft_watchdog (inputs: kick, enable; output: expired).
REQ-040 The block SHALL register every output.

Verification (N=16, NUM_STAGES=4, TIMEOUT=64)
REQ-041 Nominal frame: start, 16 in_valid, stage_done[0..3] 10 cycles apart, 16 out_valid -> stage_start bits 0,1,2,3 pulse in order, each 1 cycle after its trigger, then frame_done 1 cycle after the 16th out_valid, and err=000.
REQ-042 Back-to-back frames: start during RUN -> the FSM enters LOAD directly after frame_done, with no IDLE cycle, and err=000.
REQ-043 Overrun: three starts during LOAD -> err=100 and exactly two frames complete.
REQ-044 Stall: stage_done[2] withheld -> abort pulses 64 cycles after stage_start[2], err=001 and the FSM is in IDLE.
REQ-045 Sequence error: stage_done[3] while idx=1 -> err=010, no stage_start pulse results, and the frame still completes normally.
REQ-046 Reset after 8 in_valid -> all outputs are 0 one cycle later, and a new 16-sample frame then completes cleanly.
